mem_dma_master: RTL

- Bus initiator for the 8-bit synchronous program/data memory: drives Address/WE/DataIn and consumes the registered DataOut (1-cycle read latency).
- Performs block copy of Length bytes from SrcAddr to DstAddr, ascending.
- Sits beside the 6502 core and owns the memory port only while granted (BusReq/BusGrant); used for program loading and test-data setup.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_dma_master_if.sv | 31 +++
 rtl/mem_dma_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and state encoding for the memory-port DMA master.
// Widths match the 8-bit program/data memory beside the 6502 core.
package mem_bus_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 16;
    localparam int MEM_RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        FIN
    } dma_state_t;

endpackage

// File: rtl/mem_dma_master_if.sv
// Memory port and arbitration signals between the DMA master and the memory/arbiter.
// The master owns Address/WE/DataIn only while BusGrant is high.
interface mem_dma_master_if #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W
);
    logic              BusReq;
    logic              BusGrant;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    modport master (
        output BusReq,
        output MemWE,
        output MemAddr,
        output MemWData,
        input  BusGrant,
        input  MemRData
    );

    modport slave (
        input  BusReq,
        input  MemWE,
        input  MemAddr,
        input  MemWData,
        output BusGrant,
        output MemRData
    );
endinterface

// File: rtl/mem_dma_master.sv
// Block-copy DMA master for the synchronous 8-bit memory: ascending copy, 2 cycles/byte.
// Build option MEM_DMA_FILL_EN adds a fill mode (Fill/FillValue) that skips reads, 1 cycle/byte.
//
// state | meaning
// IDLE  | waiting for Start
// REQ   | requesting the memory port, waiting for BusGrant
// READ  | source address on the bus
// WRITE | destination written with the registered read data (or fill byte)
// FIN   | one-cycle Done pulse
module mem_dma_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W,
    parameter int LEN_W  = mem_bus_pkg::LEN_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Length,
`ifdef MEM_DMA_FILL_EN
    input  logic              Fill,
    input  logic [DATA_W-1:0] FillValue,
`endif
    output logic              Busy,
    output logic              Done,
    mem_dma_master_if.master  bus
);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              zlen_q, zlen_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fill_mode;
    logic [DATA_W-1:0] wr_byte;

`ifdef MEM_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state_q == IDLE && Start) begin
            fill_q     <= Fill;
            fill_val_q <= FillValue;
        end
    end

    assign fill_mode = fill_q;
    assign wr_byte   = fill_q ? fill_val_q : bus.MemRData;
`else
    assign fill_mode = 1'b0;
    assign wr_byte   = bus.MemRData;
`endif

    // A zero-length job idles one extra cycle in FIN so Done lands 2 cycles after Start.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        zlen_d  = zlen_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
                    cnt_d   = Length;
                    zlen_d  = (Length == '0);
                    state_d = (Length == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                if (bus.BusGrant) state_d = fill_mode ? WRITE : READ;
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1))  state_d = FIN;
                else if (!bus.BusGrant)  state_d = REQ;
                else                     state_d = fill_mode ? WRITE : READ;
            end
            FIN: begin
                if (zlen_q) zlen_d  = 1'b0;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            zlen_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            zlen_q  <= zlen_d;
            we_q    <= (state_d == WRITE);
            if (state_d == READ)       addr_q <= src_d;
            else if (state_d == WRITE) addr_q <= dst_d;
            if (state_q == WRITE)      wdata_q <= wr_byte;
        end
    end

    // Write data bypasses the register in WRITE: memory DataOut is already registered.
    assign bus.MemWData = (state_q == WRITE) ? wr_byte : wdata_q;
    assign bus.MemWE    = we_q;
    assign bus.MemAddr  = addr_q;
    assign bus.BusReq   = (state_q inside {REQ, READ, WRITE});
    assign Busy         = (state_q != IDLE);
    assign Done         = (state_q == FIN) && !zlen_q;

endmodule
